// File: rtl/uart_tx_byte.sv
// uart_tx_byte: byte-serial UART transmitter, LSB first, start + 8 data
// + optional parity + 1 or 2 stop bits. busy is combinational so the
// upstream sender sees it in the same cycle as its own req strobe.
module uart_tx_byte #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       drop
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  // done is registered, so it is raised one clock ahead of the last stop clock
  localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  if (DIV < 4) begin : g_div_chk
    $error("uart_tx_byte: CLK_FREQ/BAUD must be >= 4");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
    $error("uart_tx_byte: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("uart_tx_byte: PARITY must be 0, 1 or 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;     // data bit index in DATA, stop bit index in STOP
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;

  assign tx   = tx_q;
  assign busy = busy_q | req;
  assign done = done_q;
  assign drop = drop_q;

  // State and output registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // Next state; tx_d is the line level for the following clock, so every
  // transition also selects the first level of the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    busy_d  = busy_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (req) begin
          shift_d = data;
          par_d   = (PARITY == 1) ? ~^data : ^data;
          busy_d  = 1'b1;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        drop_d = req;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        drop_d = req;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        drop_d = req;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        drop_d = req;
        tx_d   = 1'b1;
        done_d = (bit_q == LAST_STOP) && (cnt_q == CNT_PRE);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == LAST_STOP) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_byte.sv
// tb_uart_tx_byte: four transmitter configurations (no parity, even, odd,
// two stop bits) at DIV=10, cycle-exact frame checks plus a UART receiver
// model with a byte scoreboard on the no-parity instance.
`timescale 1ns/1ps
module tb_uart_tx_byte;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] data;
  wire  [3:0] tx, busy, done, drop;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int n_drop = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx_byte #(.CLK_FREQ(1000000), .BAUD(100000), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .data(data),
    .tx(tx[0]), .busy(busy[0]), .done(done[0]), .drop(drop[0]));
  uart_tx_byte #(.CLK_FREQ(1000000), .BAUD(100000), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .data(data),
    .tx(tx[1]), .busy(busy[1]), .done(done[1]), .drop(drop[1]));
  uart_tx_byte #(.CLK_FREQ(1000000), .BAUD(100000), .PARITY(1), .STOP_BITS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .req(req[2]), .data(data),
    .tx(tx[2]), .busy(busy[2]), .done(done[2]), .drop(drop[2]));
  uart_tx_byte #(.CLK_FREQ(1000000), .BAUD(100000), .PARITY(0), .STOP_BITS(2)) u_d (
    .clk(clk), .rst_n(rst_n), .req(req[3]), .data(data),
    .tx(tx[3]), .busy(busy[3]), .done(done[3]), .drop(drop[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Line level expected in cycle c (c=1 is the first start-bit clock).
  function automatic logic exp_tx(input int c, input logic [7:0] d, input int ptype, input logic par);
    int b;
    b = (c - 1) / 10;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && ptype != 0) return par;
    return 1'b1;
  endfunction

  // Drive req in the current cycle and check every clock of the frame plus
  // the cycle after done. drop_at>0 re-asserts req in that frame cycle.
  task automatic frame_chk(input int k, input logic [7:0] d, input int ptype,
                           input int nstop, input int drop_at, input string tag);
    int n;
    logic par;
    n   = (9 + ((ptype != 0) ? 1 : 0) + nstop) * 10;
    par = (ptype == 1) ? ~^d : ^d;
    req[k] = 1'b1;
    data   = d;
    if (k == 0) sb.push_back(d);
    #1 chk({tag, "_busy_req"}, busy[k], 1);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      req[k] = (c == drop_at);
      data   = 8'($urandom);
      #1;
      chk($sformatf("%s_tx_c%0d", tag, c), tx[k], exp_tx(c, d, ptype, par));
      chk($sformatf("%s_busy_c%0d", tag, c), busy[k], 1);
      chk($sformatf("%s_done_c%0d", tag, c), done[k], (c == n));
      chk($sformatf("%s_drop_c%0d", tag, c), drop[k], (c == drop_at + 1));
    end
    @(negedge clk);
    req[k] = 1'b0;
    #1;
    chk({tag, "_post_tx"}, tx[k], 1);
    chk({tag, "_post_busy"}, busy[k], 0);
    chk({tag, "_post_done"}, done[k], 0);
    chk({tag, "_post_drop"}, drop[k], (drop_at == n));
  endtask

  // done/drop pulse counters for the no-parity instance
  always @(negedge clk) begin
    if (done[0] === 1'b1) n_done++;
    if (drop[0] === 1'b1) n_drop++;
  end

  // UART receiver model on instance A: samples mid-bit, pops the scoreboard
  int         rx_cnt = 0;
  bit         rx_on  = 1'b0;
  logic [7:0] rx_byte;
  logic [7:0] rx_exp;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx[0] === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt - 15) % 10 == 0)
        rx_byte[(rx_cnt - 15) / 10] = tx[0];
      if (rx_cnt == 95) begin
        chk("rx_stop", tx[0], 1);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $error("FAIL rx_unexpected obs=%0h exp=none", rx_byte);
        end else begin
          rx_exp = sb.pop_front();
          chk("rx_byte", rx_byte, rx_exp);
        end
        rx_on = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0, w;
    logic [7:0] d;
    rst_n = 1'b0;
    req   = '0;
    data  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", tx, 4'hF);
    chk("rst_busy", busy, 4'h0);
    chk("rst_done", done, 4'h0);
    chk("rst_drop", drop, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);

    frame_chk(0, 8'h55, 0, 1, -1, "a_55");
    @(negedge clk);
    frame_chk(1, 8'h55, 2, 1, -1, "even_55");
    @(negedge clk);
    frame_chk(1, 8'h80, 2, 1, -1, "even_80");
    @(negedge clk);
    frame_chk(2, 8'h55, 1, 1, -1, "odd_55");
    @(negedge clk);
    frame_chk(3, 8'h55, 0, 2, -1, "stop2_55");
    @(negedge clk);

    // req mid-frame, req on the done cycle, then req the cycle after done
    frame_chk(0, 8'hC3, 0, 1, 40, "a_drop40");
    @(negedge clk);
    frame_chk(0, 8'h5A, 0, 1, 100, "a_dropdone");
    frame_chk(0, 8'h0F, 0, 1, -1, "a_chain");
    @(negedge clk);

    // reset in the middle of a data bit
    req[0] = 1'b1;
    data   = 8'h3C;
    sb.push_back(8'h3C);
    for (int c = 1; c <= 54; c++) begin
      @(negedge clk);
      req[0] = 1'b0;
      #1 chk($sformatf("rstmid_tx_c%0d", c), tx[0], exp_tx(c, 8'h3C, 0, 1'b0));
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx", tx[0], 1);
    chk("rstmid_busy", busy[0], 0);
    chk("rstmid_done", done[0], 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame_chk(0, 8'hA3, 0, 1, -1, "a_a3");
    @(negedge clk);

    // sender-style pacing over a 512-byte block
    d0 = n_done;
    p0 = n_drop;
    for (int i = 0; i < 512; i++) begin
      d = 8'($urandom);
      req[0] = 1'b1;
      data   = d;
      sb.push_back(d);
      @(negedge clk);
      req[0] = 1'b0;
      #1;
      w = 0;
      while (busy[0] === 1'b1 && w < 300) begin
        @(negedge clk);
        #1;
        w++;
      end
      chk("pace_busy_bound", (w < 300), 1);
      if (w >= 300) break;
    end
    repeat (5) @(negedge clk);
    chk("pace_done_cnt", n_done - d0, 512);
    chk("pace_drop_cnt", n_drop - p0, 0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_byte.md
Name: uart_tx_byte

Overview:
- Byte-serial UART transmitter that sits directly downstream of the packet sender stage.
- Accepts one byte per single-cycle req strobe and serialises it LSB-first onto the tx line as a start bit, 8 data bits, an optional parity bit and 1 or 2 stop bits.
- Drives busy back to the sender, which uses it to pace the 512-byte block transfer.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. Bit period DIV = CLK_FREQ/BAUD, integer division, truncated. DIV must be >= 4 (elaboration-time check).
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2; any other value is an elaboration error.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  single-cycle strobe: load data and start a frame.
- data  input  8  byte to send; sampled only in the req cycle.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress, or in any cycle req is high.
- done  output  1  single-cycle pulse on the last clock of the final stop bit.
- drop  output  1  single-cycle pulse when req arrives while a frame is already in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE, tx=1, done=0, drop=0, internal busy flag 0, baud counter 0, bit counter 0.
  - Reset mid-frame aborts immediately; tx returns high with no partial stop bit.
- busy = busy_flag OR req, combinational.
  - This guarantees the sender sees busy high in the same cycle its req is high.
  - All other outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - On req: latch data into the shift register, compute the parity bit (odd: ~^data; even: ^data), set busy_flag, clear the baud counter, go to START.
  - tx goes low on the next clock edge, i.e. one cycle after req.
- Bit timing: every state holds tx for exactly DIV clocks. The baud counter runs 0..DIV-1 and the state advances when counter == DIV-1.
- START: tx=0 for DIV clocks, then DATA with bit index 0.
- DATA:
  - tx = shift[0]; shift right at the end of each bit period.
  - After index 7, go to PARITY if PARITY != 0, else to STOP.
- PARITY: tx = parity bit for DIV clocks, then STOP.
- STOP:
  - tx=1 for DIV*STOP_BITS clocks.
  - On the last clock: done=1 and the state returns to IDLE on the next edge.
  - busy_flag clears on that same edge.
- Frame length in clocks:
  - no parity, 1 stop: 10*DIV.
  - parity, 1 stop: 11*DIV.
  - 2 stop bits: add DIV.
- req while busy_flag=1 (any non-IDLE state): ignored, frame unaffected, drop pulses for one cycle.
- req in the same cycle done is high: also dropped (busy_flag still set).
- Back-to-back frames: minimum one IDLE cycle between frames. Next req accepted no earlier than the cycle after done.
- data is ignored outside the req cycle; changing data mid-frame has no effect.

Test Plan:
- CLK_FREQ=1000000, BAUD=100000 (DIV=10), PARITY=0, STOP=1; req with data=0x55:
  - tx low cycles 1-10, then bits 1,0,1,0,1,0,1,0 at 10 cycles each, stop high cycles 91-100.
  - done pulses at cycle 100; busy high from the req cycle through cycle 100.
- Same config, PARITY=2, data=0x55 -> parity bit 0 in cycles 91-100, done at 110. Repeat with PARITY=1 -> parity bit 1.
- PARITY=2, data=0x80 -> parity bit 1. STOP_BITS=2 with no parity -> tx high cycles 91-110, done at 110.
- Second req issued at cycle 40 of a frame -> drop pulses once, frame bits unchanged. Req one cycle after done -> new frame starts cleanly.
- rst_n pulled low at cycle 55 mid-DATA -> tx=1 and busy=0 immediately. After release, req with 0xA3 -> full correct frame.
- Loop the data_send-style pacing for 512 bytes (req, wait !busy, repeat) -> exactly 512 done pulses, 0 drop pulses, every byte matches in a UART receiver model.
